// File: rtl/core_pkg.sv
// Shared encodings for the core run-control sequencer: command opcodes,
// halt reasons and the sequencer state enum.
package core_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned HR_W = 2;

    typedef enum logic [OP_W-1:0] {
        CMD_HALT    = 2'd0,
        CMD_RUN     = 2'd1,
        CMD_STEP    = 2'd2,
        CMD_CLR_CNT = 2'd3
    } cmd_op_e;

    typedef enum logic [HR_W-1:0] {
        HR_RESET = 2'd0,
        HR_CMD   = 2'd1,
        HR_STEP  = 2'd2,
        HR_BP    = 2'd3
    } halt_reason_e;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } run_state_e;

endpackage

// File: rtl/core_bp_match.sv
// PC breakpoint comparator. The skip flag masks one match so that a resume
// from a breakpoint halt executes the breakpoint instruction exactly once.
module core_bp_match #(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic            skip_set,
    input  logic            skip_clr,
    output logic            bp_hit
);

    logic bp_skip;

    // Set only on leaving HALTED, where clk_en is low, so it never meets a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bp_skip <= 1'b0;
        end else if (skip_set) begin
            bp_skip <= 1'b1;
        end else if (skip_clr) begin
            bp_skip <= 1'b0;
        end
    end

    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer owning the core clock enable: settle hold after reset,
// then free-run / step / halt on host command or PC breakpoint.
module core_run_ctrl
    import core_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned STEP_W      = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter bit          AUTO_RUN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              clk_en,
    output logic              halted,
    output logic [1:0]        halt_reason,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STEP_W-1:0] step_rem_q, step_rem_d;
    halt_reason_e      hr_q, hr_d;
    logic [CNT_W-1:0]  cnt_q;

    cmd_op_e op;
    logic    cmd_fire;
    logic    bp_hit;
    logic    skip_set;
    logic    skip_clr;
    logic    resume_from_bp;

    assign op             = cmd_op_e'(cmd_op);
    assign cmd_ready      = (state_q != ST_HOLD);
    assign cmd_fire       = cmd_valid & cmd_ready;
    assign halted         = (state_q == ST_HALTED);
    assign clk_en         = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~bp_hit;
    assign halt_reason    = hr_q;
    assign cycle_cnt      = cnt_q;
    assign resume_from_bp = (state_q == ST_HALTED) & (hr_q == HR_BP);

    core_bp_match #(
        .PC_W (PC_W)
    ) u_bp_match (
        .clk      (clk),
        .rst      (rst),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .skip_set (skip_set),
        .skip_clr (skip_clr),
        .bp_hit   (bp_hit)
    );

    // State and step/hold bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            step_rem_q <= '0;
            hr_q       <= HR_RESET;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            step_rem_q <= step_rem_d;
            hr_q       <= hr_d;
        end
    end

    // Next state: autonomous events first, an accepted command overrides them.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        step_rem_d = step_rem_q;
        hr_d       = hr_q;
        skip_set   = 1'b0;
        skip_clr   = clk_en;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = AUTO_RUN ? ST_RUN : ST_HALTED;
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    state_d = ST_HALTED;
                    hr_d    = HR_BP;
                end
            end
            ST_STEP: begin
                if (bp_hit) begin
                    state_d = ST_HALTED;
                    hr_d    = HR_BP;
                end else begin
                    step_rem_d = step_rem_q - STEP_W'(1);
                    if (step_rem_q == STEP_W'(1)) begin
                        state_d = ST_HALTED;
                        hr_d    = HR_STEP;
                    end
                end
            end
            ST_HALTED: begin
            end
        endcase

        if (cmd_fire) begin
            case (op)
                CMD_HALT: begin
                    state_d  = ST_HALTED;
                    hr_d     = HR_CMD;
                    skip_clr = 1'b1;
                end
                CMD_RUN: begin
                    state_d  = ST_RUN;
                    skip_set = resume_from_bp;
                end
                CMD_STEP: begin
                    state_d    = ST_STEP;
                    step_rem_d = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
                    skip_set   = resume_from_bp;
                end
                CMD_CLR_CNT: begin
                end
            endcase
        end
    end

    // Enabled-cycle counter; a clear drops the increment of the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cmd_fire && (op == CMD_CLR_CNT)) begin
            cnt_q <= '0;
        end else if (clk_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus a randomized run checked
// against a behavioural model of the run-control rules.
module tb_core_run_ctrl;

    logic clk;
    int   total;
    int   bad;

    // Instance 0: default parameters
    logic        rst0, cmd_valid0, cmd_ready0, bp_en0, clk_en0, halted0;
    logic [1:0]  cmd_op0, halt_reason0;
    logic [7:0]  cmd_arg0;
    logic [15:0] bp_addr0, pc0;
    logic [31:0] cycle_cnt0;

    // Instance 1: AUTO_RUN=1, 4-bit counter
    logic        rst1, cmd_valid1, cmd_ready1, bp_en1, clk_en1, halted1;
    logic [1:0]  cmd_op1, halt_reason1;
    logic [7:0]  cmd_arg1;
    logic [15:0] bp_addr1, pc1;
    logic [3:0]  cycle_cnt1;

    core_run_ctrl #(.PC_W(16), .STEP_W(8), .CNT_W(32), .HOLD_CYCLES(3), .AUTO_RUN(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op0), .cmd_arg(cmd_arg0), .bp_en(bp_en0), .bp_addr(bp_addr0),
        .pc(pc0), .clk_en(clk_en0), .halted(halted0), .halt_reason(halt_reason0),
        .cycle_cnt(cycle_cnt0)
    );

    core_run_ctrl #(.PC_W(16), .STEP_W(8), .CNT_W(4), .HOLD_CYCLES(3), .AUTO_RUN(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op1), .cmd_arg(cmd_arg1), .bp_en(bp_en1), .bp_addr(bp_addr1),
        .pc(pc1), .clk_en(clk_en1), .halted(halted1), .halt_reason(halt_reason1),
        .cycle_cnt(cycle_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One core cycle on instance 0; the bench plays the core and advances pc.
    task automatic run_cycle0(output logic en);
        #1;
        en = clk_en0;
        tick();
        if (en) pc0 = pc0 + 16'd1;
    endtask

    task automatic send0(input logic [1:0] op, input logic [7:0] arg);
        logic en;
        cmd_valid0 = 1'b1;
        cmd_op0    = op;
        cmd_arg0   = arg;
        run_cycle0(en);
        cmd_valid0 = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (clk_en0 !== 1'b0 || halted0 !== 1'b0 || cmd_ready0 !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: clk_en=%b halted=%b ready=%b want 0 0 0", clk_en0, halted0, cmd_ready0); end
        total++; if (cycle_cnt0 !== 32'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d want 0", cycle_cnt0); end
        rst0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (clk_en0 !== 1'b0 || halted0 !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d: clk_en=%b halted=%b want 0 0", i, clk_en0, halted0); end
            tick();
        end
        total++; if (halted0 !== 1'b1 || halt_reason0 !== 2'd0 || cmd_ready0 !== 1'b1 || cycle_cnt0 !== 32'd0) begin
            bad++; $display("FAIL after_hold: halted=%b hr=%0d ready=%b cnt=%0d want 1 0 1 0",
                            halted0, halt_reason0, cmd_ready0, cycle_cnt0); end
    endtask

    task automatic test_step;
        int   n;
        logic en;
        send0(2'd2, 8'd5);
        n = 0;
        for (int k = 0; k < 30 && !halted0; k++) begin
            run_cycle0(en);
            if (en) n++;
        end
        total++; if (n != 5 || halted0 !== 1'b1 || halt_reason0 !== 2'd2 || cycle_cnt0 !== 32'd5) begin
            bad++; $display("FAIL step5: en_cycles=%0d halted=%b hr=%0d cnt=%0d want 5 1 2 5",
                            n, halted0, halt_reason0, cycle_cnt0); end
        send0(2'd2, 8'd0);
        n = 0;
        for (int k = 0; k < 30 && !halted0; k++) begin
            run_cycle0(en);
            if (en) n++;
        end
        total++; if (n != 1 || halt_reason0 !== 2'd2 || cycle_cnt0 !== 32'd6) begin
            bad++; $display("FAIL step0: en_cycles=%0d hr=%0d cnt=%0d want 1 2 6", n, halt_reason0, cycle_cnt0); end
    endtask

    task automatic test_breakpoint;
        logic        en;
        logic [15:0] drop_pc;
        logic        dropped;
        pc0      = 16'h0000;
        bp_en0   = 1'b1;
        bp_addr0 = 16'h0010;
        dropped  = 1'b0;
        drop_pc  = 16'hffff;
        send0(2'd1, 8'd0);
        for (int k = 0; k < 60 && !halted0; k++) begin
            #1;
            if (!clk_en0 && !dropped) begin
                dropped = 1'b1;
                drop_pc = pc0;
            end
            run_cycle0(en);
        end
        total++; if (drop_pc !== 16'h0010 || halted0 !== 1'b1 || halt_reason0 !== 2'd3) begin
            bad++; $display("FAIL bp_halt: drop_pc=%h halted=%b hr=%0d want 0010 1 3", drop_pc, halted0, halt_reason0); end
        total++; if (cycle_cnt0 !== 32'd22) begin
            bad++; $display("FAIL bp_cnt: got %0d want 22", cycle_cnt0); end
        send0(2'd1, 8'd0);
        #1;
        total++; if (clk_en0 !== 1'b1 || pc0 !== 16'h0010) begin
            bad++; $display("FAIL bp_resume: clk_en=%b pc=%h want 1 0010", clk_en0, pc0); end
        for (int k = 0; k < 4; k++) run_cycle0(en);
        send0(2'd0, 8'd0);
        total++; if (pc0 !== 16'h0015 || halted0 !== 1'b1 || halt_reason0 !== 2'd1 || cycle_cnt0 !== 32'd27) begin
            bad++; $display("FAIL bp_continue: pc=%h halted=%b hr=%0d cnt=%0d want 0015 1 1 27",
                            pc0, halted0, halt_reason0, cycle_cnt0); end
        bp_en0 = 1'b0;
    endtask

    task automatic test_halt_mid_step;
        int   n;
        logic en;
        send0(2'd3, 8'd0);
        total++; if (cycle_cnt0 !== 32'd0) begin
            bad++; $display("FAIL clr_halted: got %0d want 0", cycle_cnt0); end
        send0(2'd2, 8'd10);
        for (int k = 0; k < 3; k++) run_cycle0(en);
        send0(2'd0, 8'd0);
        total++; if (halted0 !== 1'b1 || halt_reason0 !== 2'd1 || cycle_cnt0 !== 32'd4) begin
            bad++; $display("FAIL halt_mid_step: halted=%b hr=%0d cnt=%0d want 1 1 4", halted0, halt_reason0, cycle_cnt0); end
        send0(2'd2, 8'd10);
        for (int k = 0; k < 2; k++) run_cycle0(en);
        send0(2'd2, 8'd3);
        n = 0;
        for (int k = 0; k < 30 && !halted0; k++) begin
            run_cycle0(en);
            if (en) n++;
        end
        total++; if (n != 3 || halt_reason0 !== 2'd2 || cycle_cnt0 !== 32'd10) begin
            bad++; $display("FAIL step_restart: en_cycles=%0d hr=%0d cnt=%0d want 3 2 10", n, halt_reason0, cycle_cnt0); end
    endtask

    task automatic test_reset_during_run;
        logic en;
        send0(2'd1, 8'd0);
        run_cycle0(en);
        run_cycle0(en);
        rst0 = 1'b0;
        tick();
        total++; if (clk_en0 !== 1'b0 || halted0 !== 1'b0 || cmd_ready0 !== 1'b0 || cycle_cnt0 !== 32'd0) begin
            bad++; $display("FAIL reset_mid_run: clk_en=%b halted=%b ready=%b cnt=%0d want 0 0 0 0",
                            clk_en0, halted0, cmd_ready0, cycle_cnt0); end
        rst0 = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        total++; if (halted0 !== 1'b1 || halt_reason0 !== 2'd0) begin
            bad++; $display("FAIL rehold: halted=%b hr=%0d want 1 0", halted0, halt_reason0); end
    endtask

    // Model: mode 0=halted 1=running 2=stepping; skip masks one breakpoint match.
    task automatic test_random;
        int          m_mode, m_rem, m_hr;
        logic        m_skip, hit, exp_en;
        logic [31:0] m_cnt;
        int          n_mode, n_rem, n_hr;
        logic        n_skip;
        logic [31:0] n_cnt;
        m_mode = 0; m_rem = 0; m_hr = 0; m_skip = 1'b0; m_cnt = 32'd0;
        pc0 = 16'd0; bp_addr0 = 16'd8; bp_en0 = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            cmd_valid0 = ($urandom_range(0, 7) == 0);
            cmd_op0    = 2'($urandom_range(0, 3));
            cmd_arg0   = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 31) == 0) bp_en0 = ~bp_en0;
            if ($urandom_range(0, 15) == 0) bp_addr0 = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) pc0 = 16'($urandom_range(0, 31));
            #1;
            hit    = bp_en0 && (pc0 == bp_addr0) && !m_skip;
            exp_en = (m_mode != 0) && !hit;
            total++; if (clk_en0 !== exp_en) begin
                bad++; $display("FAIL rand_clk_en it=%0d: got %b want %b", it, clk_en0, exp_en); end

            n_mode = m_mode; n_rem = m_rem; n_hr = m_hr;
            n_skip = exp_en ? 1'b0 : m_skip;
            n_cnt  = m_cnt + (exp_en ? 32'd1 : 32'd0);
            if (m_mode != 0 && hit) begin
                n_mode = 0; n_hr = 3;
            end else if (m_mode == 2) begin
                n_rem = m_rem - 1;
                if (m_rem == 1) begin n_mode = 0; n_hr = 2; end
            end
            if (cmd_valid0) begin
                case (cmd_op0)
                    2'd0: begin n_mode = 0; n_hr = 1; n_skip = 1'b0; end
                    2'd1: begin
                        if (m_mode == 0 && m_hr == 3) n_skip = 1'b1;
                        n_mode = 1;
                    end
                    2'd2: begin
                        if (m_mode == 0 && m_hr == 3) n_skip = 1'b1;
                        n_mode = 2;
                        n_rem  = (cmd_arg0 == 8'd0) ? 1 : int'(cmd_arg0);
                    end
                    default: n_cnt = 32'd0;
                endcase
            end
            m_mode = n_mode; m_rem = n_rem; m_hr = n_hr; m_skip = n_skip; m_cnt = n_cnt;

            tick();
            if (exp_en) pc0 = pc0 + 16'd1;
            total++; if (halted0 !== (m_mode == 0) || halt_reason0 !== 2'(m_hr) || cmd_ready0 !== 1'b1) begin
                bad++; $display("FAIL rand_state it=%0d: halted=%b hr=%0d ready=%b want %b %0d 1",
                                it, halted0, halt_reason0, cmd_ready0, (m_mode == 0), m_hr); end
            total++; if (cycle_cnt0 !== m_cnt) begin
                bad++; $display("FAIL rand_cnt it=%0d: got %0d want %0d", it, cycle_cnt0, m_cnt); end
        end
        cmd_valid0 = 1'b0;
    endtask

    task automatic test_auto_run_wrap;
        rst1 = 1'b1;
        tick();
        tick();
        total++; if (clk_en1 !== 1'b0 || cmd_ready1 !== 1'b0) begin
            bad++; $display("FAIL auto_hold: clk_en=%b ready=%b want 0 0", clk_en1, cmd_ready1); end
        tick();
        total++; if (clk_en1 !== 1'b1 || halted1 !== 1'b0 || cycle_cnt1 !== 4'd0) begin
            bad++; $display("FAIL auto_run: clk_en=%b halted=%b cnt=%0d want 1 0 0", clk_en1, halted1, cycle_cnt1); end
        for (int k = 0; k < 17; k++) tick();
        total++; if (cycle_cnt1 !== 4'd1) begin
            bad++; $display("FAIL cnt_wrap: got %0d want 1", cycle_cnt1); end
        cmd_valid1 = 1'b1;
        cmd_op1    = 2'd3;
        tick();
        cmd_valid1 = 1'b0;
        total++; if (cycle_cnt1 !== 4'd0 || clk_en1 !== 1'b1) begin
            bad++; $display("FAIL clr_running: cnt=%0d clk_en=%b want 0 1", cycle_cnt1, clk_en1); end
        tick();
        tick();
        total++; if (cycle_cnt1 !== 4'd2) begin
            bad++; $display("FAIL count_resume: got %0d want 2", cycle_cnt1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst0 = 1'b0; cmd_valid0 = 1'b0; cmd_op0 = 2'd0; cmd_arg0 = 8'd0;
        bp_en0 = 1'b0; bp_addr0 = 16'd0; pc0 = 16'd0;
        rst1 = 1'b0; cmd_valid1 = 1'b0; cmd_op1 = 2'd0; cmd_arg1 = 8'd0;
        bp_en1 = 1'b0; bp_addr1 = 16'd0; pc1 = 16'd0;
        tick();
        tick();
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_mid_step();
        test_reset_during_run();
        test_random();
        test_auto_run_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run-control sequencer for `core`. It owns the core's `clk_en` input and is the only block that drives it.
- After reset it holds the core stalled for a programmable settle period. It then free-runs, single-/multi-steps or halts the core on command or on a PC breakpoint.
- It keeps a count of cycles in which the core was enabled.
- It sits between the debug/host command interface and `core`, in place of the fixed `clk_en` timing used at bench level today.

Parameters:
- PC_W, 16, width of core program counter and breakpoint address.
- STEP_W, 8, width of step-count argument.
- CNT_W, 32, width of enabled-cycle counter.
- HOLD_CYCLES, 3, cycles spent in HOLD after reset release before leaving HOLD; must be ≥1.
- AUTO_RUN, 0, 1 = enter RUN after HOLD; 0 = enter HALTED after HOLD.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low; rst=0 at a rising edge resets the block.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a rising edge.
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=CLR_CNT.
- cmd_arg  in  STEP_W  step count for STEP.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint address.
- pc  in  PC_W  current core PC, i.e. the instruction executed when clk_en=1 this cycle.
- clk_en  out  1  core clock enable (combinational from state, pc, bp).
- halted  out  1  state==HALTED.
- halt_reason  out  2  0=reset, 1=HALT cmd, 2=step done, 3=breakpoint.
- cycle_cnt  out  CNT_W  number of cycles with clk_en=1, wraps modulo 2^CNT_W.

Behaviour:
- States: HOLD, HALTED, RUN, STEP.
- Reset (rst=0 at edge): state=HOLD, hold_cnt=0, step_rem=0, bp_skip=0, halt_reason=0, cycle_cnt=0. Reset mid-RUN/STEP takes effect on that edge; clk_en=0 from the next cycle.
- Outputs during reset/HOLD: clk_en=0, halted=0, cmd_ready=0.
- HOLD: hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES-1, next state is RUN if AUTO_RUN else HALTED; halt_reason stays 0.
- cmd_ready=1 in HALTED, RUN and STEP. A command is acted on at the accepting edge and its effect is visible in the next cycle.
- Breakpoint hit: bp_hit = bp_en & (pc==bp_addr) & ~bp_skip.
- clk_en = (state==RUN | state==STEP) & ~bp_hit.
- RUN: on bp_hit go to HALTED, halt_reason=3. The matching instruction is not executed.
- STEP:
  - Each clk_en cycle decrements step_rem.
  - When step_rem==1 and clk_en=1, go to HALTED with halt_reason=2.
  - bp_hit in STEP goes to HALTED with halt_reason=3.
- HALT cmd: any of HALTED/RUN/STEP → HALTED, halt_reason=1. A HALT while already HALTED still updates halt_reason to 1.
- RUN cmd: → RUN from any accepting state.
- STEP cmd: → STEP with step_rem=cmd_arg; cmd_arg=0 is treated as 1. A STEP issued while in STEP restarts the count.
- CLR_CNT cmd: cycle_cnt=0 at that edge; the current edge's increment is discarded. State is unchanged.
- bp_skip:
  - Set when leaving HALTED via RUN/STEP and the previous halt_reason==3.
  - Cleared after the first clk_en=1 cycle, and on any HALT, so a resume executes the breakpoint instruction once.
- Priority in one cycle, highest first: reset > accepted command > bp_hit > step completion.
- cycle_cnt wraps from all-ones to 0 with no flag.

Decomposition:
- Package `core_pkg`: cmd_op encodings (CMD_HALT/RUN/STEP/CLR_CNT), halt_reason encodings (HR_RESET/CMD/STEP/BP), and the state enum.
- One sub-module, `core_bp_match`: breakpoint comparator with bp_skip register, outputs bp_hit. The FSM, step counter and cycle counter stay in the top.

Test Plan:
- Reset release, AUTO_RUN=0, HOLD_CYCLES=3 → clk_en=0 for 3 cycles after rst=1, then halted=1, halt_reason=0, cycle_cnt=0, cmd_ready=1.
- STEP cmd_arg=5 from HALTED → clk_en=1 for exactly 5 cycles, then halted=1, halt_reason=2, cycle_cnt=5. Then STEP cmd_arg=0 → exactly 1 enabled cycle, cycle_cnt=6.
- RUN with bp_en=1, bp_addr=0x0010, pc ramping by 1 from 0 → clk_en drops in the cycle pc=0x0010, halt_reason=3. Then RUN → clk_en=1 at pc=0x0010 (bp_skip) and the core continues.
- HALT issued mid-STEP(cmd_arg=10) after 4 enabled cycles → halted=1 next cycle, halt_reason=1, cycle_cnt=4. A STEP issued during STEP restarts the remaining count.
- CNT_W=4: RUN for 17 cycles → cycle_cnt=1 (wrap). CLR_CNT while running → cycle_cnt=0 next cycle and counting resumes.
- rst=0 asserted during RUN → clk_en=0 next cycle, state HOLD, cycle_cnt=0, cmd_ready=0. Also check AUTO_RUN=1: RUN entered after HOLD_CYCLES with no command.
